// File: rtl/mnist_tmpl_classifier_if.sv
// Request, image, weight-load and result signals of mnist_tmpl_classifier.
// master drives requests and weight writes; slave is the classifier side.
interface mnist_tmpl_classifier_if #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int N_CLASS = 10,
   parameter int WT_W    = 8,
   parameter int ACC_W   = 20
);
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int ADDR_W = $clog2(N_CLASS * NPIX);

   logic              start;
   logic [NPIX-1:0]   img_in;
   logic              invert;
   logic              wt_we;
   logic [ADDR_W-1:0] wt_addr;
   logic [WT_W-1:0]   wt_data;
   logic              busy;
   logic              done;
   logic [3:0]        digit;
   logic [ACC_W-1:0]  score;
   logic [6:0]        hex_out;
   logic              wt_err;

   modport master (
      output start, img_in, invert, wt_we, wt_addr, wt_data,
      input  busy, done, digit, score, hex_out, wt_err
   );

   modport slave (
      input  start, img_in, invert, wt_we, wt_addr, wt_data,
      output busy, done, digit, score, hex_out, wt_err
   );
endinterface

// File: rtl/mnist_tmpl_classifier.sv
// Binary-image template classifier: per-class signed weighted pixel sum with
// saturating accumulation, argmax over classes, 7-segment display of the winner.
module mnist_tmpl_classifier #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int N_CLASS = 10,
   parameter int WT_W    = 8,
   parameter int ACC_W   = 20
) (
   input logic                  clk,
   input logic                  rst_n,
   mnist_tmpl_classifier_if.slave bus
);
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int NWT    = N_CLASS * NPIX;
   localparam int ADDR_W = $clog2(NWT);
   localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [ADDR_W:0]        NWT_L   = (ADDR_W + 1)'(NWT);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

   typedef enum logic [2:0] {IDLE, CAPT, MAC, CMP, DONE} state_t;

   state_t state, state_nx;

   logic [WT_W-1:0]          wmem [NWT];
   logic [NPIX-1:0]          img_r;
   logic                     inv_r;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  best;
   logic signed [ACC_W-1:0]  score_r;
   logic signed [ACC_W-1:0]  acc_sat;
   logic [ACC_W:0]           sum;
   logic [3:0]               cls;
   logic [3:0]               best_idx;
   logic [3:0]               digit_r;
   logic [PIX_W-1:0]         pix;
   logic [ADDR_W-1:0]        rd_addr;
   logic [WT_W-1:0]          w_rd;
   logic                     done_r;
   logic                     wt_err_r;
   logic                     busy;
   logic                     last_pix;
   logic                     last_cls;
   logic                     wr_ok;
   logic [6:0]               hex;

   assign last_pix = (pix == PIX_W'(NPIX - 1));
   assign last_cls = (cls == 4'(N_CLASS - 1));
   assign rd_addr  = ADDR_W'(cls) * ADDR_W'(NPIX) + ADDR_W'(pix);
   assign w_rd     = wmem[rd_addr];
   assign wr_ok    = bus.wt_we && !busy && ({1'b0, bus.wt_addr} < NWT_L);

   // One guard bit catches overflow; clamp toward the true sign instead of wrapping.
   always_comb begin
      sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - WT_W){w_rd[WT_W-1]}}, w_rd};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sat = sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         wmem[bus.wt_addr] <= bus.wt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      unique case (state)
         IDLE: if (bus.start) state_nx = CAPT;
         CAPT: begin
            busy     = 1'b1;
            state_nx = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (last_pix) state_nx = CMP;
         end
         CMP: begin
            busy     = 1'b1;
            state_nx = last_cls ? DONE : MAC;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // invert is captured alongside start so the image latch in CAPT does not
   // depend on invert still being held by the requester.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         cls      <= '0;
         pix      <= '0;
         best     <= ACC_MIN;
         best_idx <= '0;
         img_r    <= '0;
         inv_r    <= 1'b0;
         digit_r  <= '0;
         score_r  <= '0;
         done_r   <= 1'b0;
         wt_err_r <= 1'b0;
      end else begin
         done_r   <= 1'b0;
         wt_err_r <= bus.wt_we && !wr_ok;
         unique case (state)
            IDLE: if (bus.start) inv_r <= bus.invert;
            CAPT: begin
               img_r    <= bus.img_in ^ {NPIX{inv_r}};
               acc      <= '0;
               cls      <= '0;
               pix      <= '0;
               best     <= ACC_MIN;
               best_idx <= '0;
            end
            MAC: begin
               if (img_r[pix]) acc <= acc_sat;
               if (!last_pix) pix <= pix + 1'b1;
            end
            CMP: begin
               if (acc > best) begin
                  best     <= acc;
                  best_idx <= cls;
               end
               acc <= '0;
               pix <= '0;
               if (!last_cls) cls <= cls + 1'b1;
            end
            DONE: begin
               digit_r <= best_idx;
               score_r <= best;
               done_r  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      hex = 7'h7F;
      case (digit_r)
         4'd0: hex = 7'h40;
         4'd1: hex = 7'h79;
         4'd2: hex = 7'h24;
         4'd3: hex = 7'h30;
         4'd4: hex = 7'h19;
         4'd5: hex = 7'h12;
         4'd6: hex = 7'h02;
         4'd7: hex = 7'h78;
         4'd8: hex = 7'h00;
         4'd9: hex = 7'h10;
         default: hex = 7'h7F;
      endcase
   end

   assign bus.busy    = busy;
   assign bus.done    = done_r;
   assign bus.digit   = digit_r;
   assign bus.score   = score_r;
   assign bus.hex_out = hex;
   assign bus.wt_err  = wt_err_r;
endmodule

// File: tb/tb_mnist_tmpl_classifier.sv
// Bench for mnist_tmpl_classifier: 4x4 images, 3 classes, a wide-accumulator
// instance and an 8-bit-accumulator instance fed identical stimulus.
module tb_mnist_tmpl_classifier;
   localparam int NPIX    = 16;
   localparam int RUN_LAT = 3 * (NPIX + 1) + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        invert = 1'b0;
   logic        wt_we = 1'b0;
   logic [15:0] img = '0;
   logic [5:0]  wt_addr = '0;
   logic [7:0]  wt_data = '0;

   always #5 clk = ~clk;

   mnist_tmpl_classifier_if #(.IMG_W(4), .IMG_H(4), .N_CLASS(3), .WT_W(8), .ACC_W(20)) ifa ();
   mnist_tmpl_classifier_if #(.IMG_W(4), .IMG_H(4), .N_CLASS(3), .WT_W(8), .ACC_W(8))  ifb ();

   assign ifa.start   = start;
   assign ifa.img_in  = img;
   assign ifa.invert  = invert;
   assign ifa.wt_we   = wt_we;
   assign ifa.wt_addr = wt_addr;
   assign ifa.wt_data = wt_data;
   assign ifb.start   = start;
   assign ifb.img_in  = img;
   assign ifb.invert  = invert;
   assign ifb.wt_we   = wt_we;
   assign ifb.wt_addr = wt_addr;
   assign ifb.wt_data = wt_data;

   mnist_tmpl_classifier #(.IMG_W(4), .IMG_H(4), .N_CLASS(3), .WT_W(8), .ACC_W(20)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   mnist_tmpl_classifier #(.IMG_W(4), .IMG_H(4), .N_CLASS(3), .WT_W(8), .ACC_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   typedef struct {
      int digit; int score_a; int score_b; int hex; int done_cyc;
   } exp_t;
   typedef struct {
      logic [15:0] img; logic inv; int digit; int score_a; int score_b; int hex;
   } vec_t;

   exp_t sb[$];
   exp_t me;
   vec_t t1[4];
   vec_t t2[7];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   s0;
   int   win_on = 0, win_lo = 0, win_hi = 0, busy_low = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int d, input int sa, input int sbv, input int hx, input int dc);
      exp_t e;
      e.digit = d; e.score_a = sa; e.score_b = sbv; e.hex = hx; e.done_cyc = dc;
      sb.push_back(e);
   endtask

   task automatic run(input logic [15:0] im, input logic inv, input int d,
                      input int sa, input int sbv, input int hx);
      img = im; invert = inv; start = 1'b1;
      tick();
      start = 1'b0;
      push_exp(d, sa, sbv, hx, cyc + RUN_LAT);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      if (sb.size() != 0) begin
         chk("done_timeout", 0, 1);
         sb.delete();
      end
      tick();
   endtask

   task automatic wr(input int a, input int d);
      wt_we = 1'b1; wt_addr = 6'(a); wt_data = 8'(d);
      tick();
      wt_we = 1'b0;
   endtask

   // Scoreboard side: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (ifa.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            me = sb.pop_front();
            chk("done_cycle", cyc, me.done_cyc);
            chk("digit_a", int'(ifa.digit), me.digit);
            chk("score_a", int'($signed(ifa.score)), me.score_a);
            chk("hex_a", int'(ifa.hex_out), me.hex);
            chk("done_b", int'(ifb.done), 1);
            chk("digit_b", int'(ifb.digit), me.digit);
            chk("score_b", int'($signed(ifb.score)), me.score_b);
         end
      end else if (ifb.done) begin
         chk("done_b_alone", 1, 0);
      end
      if (win_on != 0 && cyc >= win_lo && cyc <= win_hi && !ifa.busy) busy_low++;
   end

   initial begin
      t1[0] = '{16'hFFFF, 1'b0, 1, 80, 80, 'h79};
      t1[1] = '{16'h0000, 1'b1, 1, 80, 80, 'h79};
      t1[2] = '{16'h0000, 1'b0, 0, 0, 0, 'h40};
      t1[3] = '{16'h00FF, 1'b0, 1, 40, 40, 'h79};
      t2[0] = '{16'hFFFF, 1'b0, 1, 32, 32, 'h79};
      t2[1] = '{16'h5555, 1'b0, 2, 32, 32, 'h24};
      t2[2] = '{16'hFF00, 1'b0, 0, 28, 28, 'h40};
      t2[3] = '{16'h0000, 1'b0, 0, 0, 0, 'h40};
      t2[4] = '{16'h8000, 1'b0, 0, 7, 7, 'h40};
      t2[5] = '{16'h00AA, 1'b1, 1, 24, 24, 'h79};
      t2[6] = '{16'h0002, 1'b0, 1, 2, 2, 'h79};

      repeat (3) tick();
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_done", int'(ifa.done), 0);
      chk("rst_digit", int'(ifa.digit), 0);
      chk("rst_score", int'(ifa.score), 0);
      chk("rst_hex", int'(ifa.hex_out), 'h40);
      chk("rst_wt_err", int'(ifa.wt_err), 0);
      chk("rst_hex_b", int'(ifb.hex_out), 'h40);
      rst_n = 1'b1;
      tick();

      for (int c = 0; c < 3; c++)
         for (int p = 0; p < NPIX; p++) wr(c * NPIX + p, (c == 1) ? 5 : 0);
      chk("wt_err_legal", int'(ifa.wt_err), 0);

      for (int i = 0; i < 4; i++) begin
         run(t1[i].img, t1[i].inv, t1[i].digit, t1[i].score_a, t1[i].score_b, t1[i].hex);
         wait_idle();
      end

      wr(48, 8'h11);
      chk("wt_err_oor", int'(ifa.wt_err), 1);
      tick();
      chk("wt_err_oor_clear", int'(ifa.wt_err), 0);

      run(16'hFFFF, 1'b0, 1, 80, 80, 'h79);
      repeat (3) tick();
      chk("digit_hold", int'(ifa.digit), 1);
      wt_we = 1'b1; wt_addr = 6'd16; wt_data = 8'(-100);
      tick();
      wt_we = 1'b0;
      chk("wt_err_busy", int'(ifa.wt_err), 1);
      tick();
      chk("wt_err_busy_clear", int'(ifa.wt_err), 0);
      wait_idle();
      run(16'hFFFF, 1'b0, 1, 80, 80, 'h79);
      wait_idle();

      img = 16'hFFFF; invert = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      chk("abort_busy", int'(ifa.busy), 0);
      chk("abort_done", int'(ifa.done), 0);
      chk("abort_digit", int'(ifa.digit), 0);
      chk("abort_hex", int'(ifa.hex_out), 'h40);
      chk("abort_score", int'(ifa.score), 0);
      rst_n = 1'b1;
      tick();
      run(16'hFFFF, 1'b0, 1, 80, 80, 'h79);
      wait_idle();

      for (int c = 0; c < 3; c++)
         for (int p = 0; p < NPIX; p++)
            wr(c * NPIX + p, (c == 0) ? (p - 8) : (c == 1) ? 2 : ((p % 2 == 0) ? 4 : -4));
      for (int i = 0; i < 7; i++) begin
         run(t2[i].img, t2[i].inv, t2[i].digit, t2[i].score_a, t2[i].score_b, t2[i].hex);
         wait_idle();
      end

      for (int a = 0; a < 48; a++) wr(a, -128);
      run(16'hFFFF, 1'b0, 0, -2048, -128, 'h40);
      wait_idle();
      for (int p = 0; p < NPIX; p++) wr(NPIX + p, 127);
      run(16'hFFFF, 1'b0, 1, 2032, 127, 'h79);
      wait_idle();

      img = 16'hFFFF; invert = 1'b0; start = 1'b1;
      tick();
      s0 = cyc;
      push_exp(1, 2032, 127, 'h79, s0 + RUN_LAT);
      push_exp(1, 2032, 127, 'h79, s0 + 2 * RUN_LAT + 1);
      win_lo = s0; win_hi = s0 + 2 * RUN_LAT - 1; busy_low = 0; win_on = 1;
      repeat (60) tick();
      start = 1'b0;
      wait_idle();
      win_on = 0;
      chk("busy_low_cycles", busy_low, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mnist_tmpl_classifier.md
MNIST_TMPL_CLASSIFIER -- requirements
Module: mnist_tmpl_classifier

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, meaning image height in pixels; NPIX = IMG_W*IMG_H.
REQ-003 SHALL have parameter N_CLASS, default 10, meaning number of classes, legal range 2..16.
REQ-004 SHALL have parameter WT_W, default 8, meaning signed two's-complement weight width.
REQ-005 SHALL have parameter ACC_W, default 20, meaning signed accumulator and score width.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit, classification request.
REQ-009 SHALL have port img_in, input, NPIX bits, binary image with pixel p = row*IMG_W+col at bit p.
REQ-010 SHALL have port invert, input, 1 bit, sampled with start; 1 = complement the image before use.
REQ-011 SHALL have port wt_we, input, 1 bit, weight write strobe.
REQ-012 SHALL have port wt_addr, input, clog2(N_CLASS*NPIX) bits, weight address = class*NPIX + pixel.
REQ-013 SHALL have port wt_data, input, WT_W bits, signed weight value.
REQ-014 SHALL have port busy, output, 1 bit, high while a classification is in progress.
REQ-015 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-016 SHALL have port digit, output, 4 bits, winning class index.
REQ-017 SHALL have port score, output, ACC_W bits, signed winning-class score.
REQ-018 SHALL have port hex_out, output, 7 bits, active-low 7-segment code of digit, segments {g,f,e,d,c,b,a}.
REQ-019 SHALL have port wt_err, output, 1 bit, one-cycle pulse flagging a rejected weight write.

Function
REQ-020 SHALL hold weights in an N_CLASS*NPIX x WT_W register array with combinational read; contents are not cleared by reset.
REQ-021 SHALL write wt_data to wt_addr on a wt_we cycle when busy=0; an address >= N_CLASS*NPIX is ignored and pulses wt_err.
REQ-022 SHALL ignore wt_we while busy=1 and pulse wt_err on the next cycle.
REQ-023 SHALL implement states IDLE, CAPT, MAC, CMP, DONE.
REQ-024 SHALL, in IDLE with start=1, go to CAPT; start during any other state is ignored.
REQ-025 SHALL, in CAPT, latch img_in XOR {NPIX{invert}} into an internal image register, clear acc, class=0, pixel=0, best=most-negative ACC_W value, best_idx=0; next state MAC.
REQ-026 SHALL, in MAC, add the sign-extended weight[class*NPIX+pixel] to acc when image bit pixel is 1, one pixel per cycle.
REQ-027 SHALL saturate acc at +(2^(ACC_W-1)-1) and -2^(ACC_W-1) rather than wrap.
REQ-028 SHALL go from MAC to CMP after pixel NPIX-1 has been processed.
REQ-029 SHALL, in CMP, replace best/best_idx with acc/class only when acc > best (signed); ties keep the lower index.
REQ-030 SHALL, in CMP, clear acc and pixel; if class < N_CLASS-1, increment class and return to MAC; otherwise go to DONE.
REQ-031 SHALL, in DONE, register digit=best_idx and score=best, assert done for exactly one cycle, and return to IDLE.
REQ-032 SHALL hold digit, score and hex_out stable from DONE until the next DONE.
REQ-033 SHALL assert busy in CAPT, MAC and CMP, and deassert it in IDLE and DONE.
REQ-034 SHALL assert done exactly N_CLASS*(NPIX+1)+2 cycles after the edge that samples start in IDLE.
REQ-035 SHALL allow a start asserted in the cycle after done to begin a new classification.
REQ-036 SHALL drive hex_out 0..9 as 40,79,24,30,19,12,02,78,00,10 (hex), and 7F for digit > 9.

Reset
REQ-037 SHALL, when rst_n=0 at a clock edge, force state IDLE, busy=0, done=0, wt_err=0, digit=0, score=0, hex_out=7'h40, acc=0, class=0, pixel=0.
REQ-038 SHALL abandon an in-progress classification on reset without asserting done; weights are preserved.

Verification
REQ-039 Parameters IMG_W=4, IMG_H=4, N_CLASS=3: load class1 weights all +5 and others 0; all-ones image, start -> done at cycle 3*17+2=53, digit=1, score=80, hex_out=79.
REQ-040 Same weights; image all zeros and invert=1 -> digit=1, score=80; invert=0 -> all scores 0, tie rule -> digit=0, score=0.
REQ-041 Class weights all -128 (WT_W=8, ACC_W=8) with all-ones image -> score saturates at -128, no wrap.
REQ-042 Pulse wt_we while busy -> write discarded (readback via rerun unchanged), wt_err one-cycle pulse; wt_addr=48 when idle -> wt_err pulse, no write.
REQ-043 Assert rst_n=0 mid-MAC -> next cycle busy=0, done=0, digit=0, hex_out=40; restart yields the same result as an uninterrupted run.
REQ-044 Start held high continuously -> back-to-back runs, done pulses spaced exactly 54 cycles apart, busy low only in DONE/IDLE cycles.
